// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the multiplexed channel scanner.
package mux_scan_pkg;

    localparam int DW_DEFAULT      = 4;
    localparam int DWELL_W_DEFAULT = 4;
    localparam int NUM_CHAN        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FINISH = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mux_channel_scanner_if.sv
// Control, mux-side and sample-stream signals of the channel scanner.
interface mux_channel_scanner_if import mux_scan_pkg::*; #(
    parameter int DW      = DW_DEFAULT,
    parameter int DWELL_W = DWELL_W_DEFAULT
);
    logic                start;
    logic                cont;
    logic                stop;
    logic [NUM_CHAN-1:0] chan_mask;
    logic [DWELL_W-1:0]  dwell;
    logic [DW-1:0]       mux_out;
    logic [1:0]          sel;
    logic [DW-1:0]       data_out;
    logic [1:0]          chan_out;
    logic                valid;
    logic                ready;
    logic                busy;
    logic                done;

    modport master (
        input  start, cont, stop, chan_mask, dwell, mux_out, ready,
        output sel, data_out, chan_out, valid, busy, done
    );

    modport slave (
        output start, cont, stop, chan_mask, dwell, mux_out, ready,
        input  sel, data_out, chan_out, valid, busy, done
    );
endinterface

// File: rtl/mux_scan_next.sv
// Finds the next set mask bit strictly above cur; optionally wraps to the lowest set bit.
module mux_scan_next import mux_scan_pkg::*; (
    input  logic [NUM_CHAN-1:0] mask,
    input  logic [1:0]          cur,
    input  logic                wrap,
    output logic [1:0]          next_idx,
    output logic                found
);
    logic [NUM_CHAN-1:0] above;
    logic [1:0]          above_idx;
    logic [1:0]          low_idx;
    logic                above_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_above
            assign above[gi] = mask[gi] && (cur < 2'(gi));
        end
    endgenerate

    // Scanning downward leaves the lowest qualifying index in each result.
    always_comb begin
        above_idx = '0;
        low_idx   = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (above[i]) above_idx = 2'(i);
            if (mask[i])  low_idx   = 2'(i);
        end
    end

    assign above_any = |above;
    assign found     = above_any || (wrap && (|mask));
    assign next_idx  = above_any ? above_idx : low_idx;
endmodule

// File: rtl/mux_channel_scanner.sv
// Steps a 4:1 mux through the enabled channels, settles, samples and hands off each value.
module mux_channel_scanner import mux_scan_pkg::*; #(
    parameter int DW      = DW_DEFAULT,
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    mux_channel_scanner_if.master bus
);
    scan_state_t         state_reg, state_next;
    logic [1:0]          sel_reg, sel_next;
    logic [1:0]          chan_reg, chan_next;
    logic [DW-1:0]       data_reg, data_next;
    logic [DWELL_W-1:0]  cnt_reg, cnt_next;
    logic [DWELL_W-1:0]  dwell_reg, dwell_next;
    logic [NUM_CHAN-1:0] mask_reg, mask_next;
    logic                valid_reg, valid_next;
    logic                cont_reg, cont_next;
    logic                stop_reg, stop_next;

    logic [1:0] first_idx, nxt_idx;
    logic       first_found, nxt_found;
    logic       stop_seen;

    // With cur=3 and wrap on, the search degenerates to "lowest set bit".
    mux_scan_next u_first (
        .mask     (bus.chan_mask),
        .cur      (2'd3),
        .wrap     (1'b1),
        .next_idx (first_idx),
        .found    (first_found)
    );

    mux_scan_next u_next (
        .mask     (mask_reg),
        .cur      (sel_reg),
        .wrap     (cont_reg),
        .next_idx (nxt_idx),
        .found    (nxt_found)
    );

    assign stop_seen = cont_reg && (stop_reg || bus.stop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            chan_reg  <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            dwell_reg <= '0;
            mask_reg  <= '0;
            valid_reg <= 1'b0;
            cont_reg  <= 1'b0;
            stop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            chan_reg  <= chan_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            dwell_reg <= dwell_next;
            mask_reg  <= mask_next;
            valid_reg <= valid_next;
            cont_reg  <= cont_next;
            stop_reg  <= stop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        chan_next  = chan_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        dwell_next = dwell_reg;
        mask_next  = mask_reg;
        valid_next = valid_reg;
        cont_next  = cont_reg;
        stop_next  = stop_reg;

        // A stop request during a continuous scan is held until the next handshake.
        if ((state_reg != ST_IDLE) && cont_reg && bus.stop) stop_next = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    if (first_found) begin
                        mask_next  = bus.chan_mask;
                        dwell_next = bus.dwell;
                        cont_next  = bus.cont;
                        stop_next  = 1'b0;
                        sel_next   = first_idx;
                        cnt_next   = bus.dwell;
                        state_next = ST_SETTLE;
                    end else begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    data_next  = bus.mux_out;
                    chan_next  = sel_reg;
                    valid_next = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.ready) begin
                    valid_next = 1'b0;
                    if (stop_seen || !nxt_found) begin
                        state_next = ST_FINISH;
                    end else begin
                        sel_next   = nxt_idx;
                        cnt_next   = dwell_reg;
                        state_next = ST_SETTLE;
                    end
                end
            end
            ST_FINISH: begin
                stop_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.sel      = sel_reg;
    assign bus.data_out = data_reg;
    assign bus.chan_out = chan_reg;
    assign bus.valid    = valid_reg;
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.done     = (state_reg == ST_FINISH);
endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboard bench: stimulus queues expected samples, a negedge monitor checks each handshake.
module tb_mux_channel_scanner;
    import mux_scan_pkg::*;

    localparam int DW      = 4;
    localparam int DWELL_W = 4;

    typedef struct packed {
        logic [1:0]    chan;
        logic [DW-1:0] data;
    } sample_t;

    logic clk = 1'b0;
    logic rst;

    mux_channel_scanner_if #(.DW(DW), .DWELL_W(DWELL_W)) bus ();

    mux_channel_scanner #(.DW(DW), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Downstream mux model: channel i returns 0xA+i.
    always_comb bus.mux_out = 4'hA + {2'b00, bus.sel};

    sample_t exp_q[$];
    sample_t exp_s;
    int      checks    = 0;
    int      errors    = 0;
    int      cyc       = 0;
    int      ref_cyc   = 0;
    int      exp_dwell = 0;
    int      done_cnt  = 0;
    logic    prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.valid && !prev_valid) begin
            checks++;
            if (cyc - ref_cyc != exp_dwell + 1) begin
                errors++;
                $display("FAIL latency: valid rose after %0d cycles, expected %0d", cyc - ref_cyc, exp_dwell + 1);
            end
        end
        if (bus.valid && bus.ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: got ch%0d data 0x%h, expected no sample", bus.chan_out, bus.data_out);
            end else begin
                exp_s = exp_q.pop_front();
                if (bus.chan_out !== exp_s.chan || bus.data_out !== exp_s.data) begin
                    errors++;
                    $display("FAIL sample: got ch%0d data 0x%h, expected ch%0d data 0x%h",
                             bus.chan_out, bus.data_out, exp_s.chan, exp_s.data);
                end else begin
                    $display("sample ok: ch%0d data 0x%h at cycle %0d", bus.chan_out, bus.data_out, cyc);
                end
            end
            ref_cyc = cyc + 1;
        end
        prev_valid = bus.valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic push(input int ch);
        exp_q.push_back({2'(ch), DW'(4'hA + ch)});
    endtask

    task automatic start_scan(input logic [3:0] m, input int d, input logic c);
        bus.chan_mask = m;
        bus.dwell     = DWELL_W'(d);
        bus.cont      = c;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        ref_cyc   = cyc;
        exp_dwell = d;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_idle_timeout"}, int'(ok), 1);
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_valid_timeout"}, int'(ok), 1);
    endtask

    task automatic handshake(input string name);
        wait_valid(name);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_sel"},   int'(bus.sel), 0);
        chk({name, "_data"},  int'(bus.data_out), 0);
        chk({name, "_chan"},  int'(bus.chan_out), 0);
        chk({name, "_valid"}, int'(bus.valid), 0);
        chk({name, "_busy"},  int'(bus.busy), 0);
        chk({name, "_done"},  int'(bus.done), 0);
    endtask

    initial begin
        int d0;
        logic [DW-1:0] held_data;
        logic [1:0]    held_chan;
        bit            sel_ok;

        rst = 1'b1;
        bus.start = 1'b0; bus.cont = 1'b0; bus.stop = 1'b0; bus.ready = 1'b0;
        bus.chan_mask = '0; bus.dwell = '0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // All four channels, no dwell, always ready
        bus.ready = 1'b1;
        d0 = done_cnt;
        for (int c = 0; c < 4; c++) push(c);
        start_scan(4'b1111, 0, 1'b0);
        wait_idle("t1");
        tick();
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Sparse mask with dwell 3
        d0 = done_cnt;
        push(0); push(2);
        start_scan(4'b0101, 3, 1'b0);
        wait_idle("t2");
        tick();
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Back-pressure: ready low for 5 cycles
        bus.ready = 1'b0;
        push(1);
        start_scan(4'b0010, 0, 1'b0);
        wait_valid("t3");
        held_data = bus.data_out;
        held_chan = bus.chan_out;
        chk("t3_data", int'(held_data), 'hB);
        chk("t3_chan", int'(held_chan), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", int'(bus.valid), 1);
            chk("t3_hold_data", int'(bus.data_out), int'(held_data));
            chk("t3_hold_chan", int'(bus.chan_out), int'(held_chan));
        end
        tick();
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        @(negedge clk);
        chk("t3_done_after_hs", int'(bus.done), 1);
        chk("t3_valid_after_hs", int'(bus.valid), 0);
        @(negedge clk);
        chk("t3_done_one_cycle", int'(bus.done), 0);
        tick();

        // Continuous mode with stop during the second ch0 sample
        d0 = done_cnt;
        push(0); push(3); push(0);
        start_scan(4'b1001, 0, 1'b1);
        handshake("t4_a");
        handshake("t4_b");
        wait_valid("t4_c");
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        handshake("t4_c");
        wait_idle("t4");
        tick();
        chk("t4_done_pulses", done_cnt - d0, 1);
        chk("t4_queue_empty", exp_q.size(), 0);
        bus.cont = 1'b0;

        // Reset during SETTLE of ch2, then restart
        bus.ready = 1'b1;
        push(0); push(1);
        start_scan(4'b1111, 3, 1'b0);
        sel_ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.sel == 2'd2 && !bus.valid) begin
                sel_ok = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_reached_ch2", int'(sel_ok), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_zero("t5_reset");
        chk("t5_queue_empty", exp_q.size(), 0);
        tick();
        for (int c = 0; c < 4; c++) push(c);
        start_scan(4'b1111, 0, 1'b0);
        wait_idle("t5");
        chk("t5_restart_queue", exp_q.size(), 0);
        tick();

        // Empty mask: immediate done, no valid
        d0 = done_cnt;
        bus.chan_mask = 4'b0000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("t6_done", int'(bus.done), 1);
        chk("t6_valid", int'(bus.valid), 0);
        tick();
        wait_idle("t6");

        // start plus mask/dwell changes while busy are ignored
        push(0); push(1);
        start_scan(4'b0011, 2, 1'b0);
        bus.start = 1'b1;
        bus.chan_mask = 4'b1100;
        bus.dwell = '0;
        tick();
        tick();
        bus.start = 1'b0;
        wait_idle("t7");
        tick();
        chk("t7_done_pulses", done_cnt - d0, 2);
        chk("t7_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
